pkt_rr_arb2: RTL and testbench
==============================

Name: pkt_rr_arb2

Overview:
- Two-input, packet-granular round-robin arbiter that merges two show-ahead packet FIFO read ports onto one downstream packet stream.
- Each input carries the {sop, eop, data} word format used by the team's packet FIFO wrappers. The arbiter drives each FIFO's read request and registers the selected beat toward the sink.
- Once a packet is granted, the grant is held until that packet's eop beat is transferred, so packets from the two sources never interleave.

Parameters:
- DATA_W, 8, data width of each beat.
- MAX_LEN, 256, maximum packet length in beats. Used only with PKT_LEN_CHK_EN.
- CNT_W, 16, width of the per-port packet counters.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- s0_dat  in  DATA_W  port 0 head-of-FIFO data.
- s0_vld  in  1  port 0 FIFO not empty.
- s0_sop  in  1  port 0 head beat is start of packet.
- s0_eop  in  1  port 0 head beat is end of packet.
- s0_rd  out  1  port 0 read request; the head beat is consumed when s0_vld && s0_rd.
- s1_dat, s1_vld, s1_sop, s1_eop, s1_rd  as port 0, for port 1.
- dout  out  DATA_W  output beat data.
- dout_vld  out  1  output beat valid.
- dout_sop  out  1  output start of packet; qualified by dout_vld.
- dout_eop  out  1  output end of packet; qualified by dout_vld.
- out_rdy  in  1  sink can accept the beat produced next cycle.
- err  out  1  one-cycle pulse on a protocol error.
- pkt_cnt0  out  CNT_W  packets forwarded from port 0.
- pkt_cnt1  out  CNT_W  packets forwarded from port 1.

Behaviour:
- Reset: all outputs 0, state IDLE, round-robin pointer = port 0 has priority, counters 0. A reset asserted mid-packet abandons that packet; no eop is emitted.
- States: IDLE, GNT0, GNT1.
- IDLE, request seen:
  - req_i = si_vld && si_sop.
  - Only one requester: grant it.
  - Both requesting: grant the port not granted last (pointer). The pointer updates when the grant is issued.
  - The grant is combinational in the same cycle: si_rd = out_rdy, and the sop beat transfers in that cycle if out_rdy=1.
- IDLE, stray beat: if si_vld && !si_sop, assert si_rd to discard the beat, pulse err, do not forward it. If both ports hold stray beats, discard both in the same cycle; err is a single pulse.
- GNTi:
  - si_rd = si_vld && out_rdy; the other port's rd = 0.
  - A transferred beat with eop returns to IDLE the next cycle.
  - A sop seen mid-packet (transferred, non-first beat) is forwarded with dout_sop forced to 0 and pulses err; the grant is kept.
- Single-beat packet (sop && eop): forwarded and the grant released, all in one transfer cycle.
- Output register, latency 1. On every cycle, dout_vld <= (s0_vld && s0_rd && forwarded) || (s1_vld && s1_rd && forwarded).
  - dout is updated only when a beat is forwarded.
  - dout_sop and dout_eop <= the beat's flags when forwarded, else 0.
- out_rdy semantics match the FIFO wrappers: out_rdy sampled low in cycle N guarantees no new beat in cycle N+1.
- Throughput: one beat per cycle within a packet. One idle cycle between packets: the transition GNT to IDLE costs one cycle with no rd asserted.
- Counters:
  - pkt_cnti increments when an eop beat from port i is forwarded.
  - Counters wrap modulo 2^CNT_W.
  - Discarded stray beats never count.

Optional Feature:
- Macro PKT_LEN_CHK_EN.
- When defined:
  - A beat counter in GNTi counts forwarded beats.
  - If MAX_LEN beats have been forwarded without eop, the MAX_LEN-th beat is emitted with dout_eop forced to 1, err pulses, and pkt_cnti increments.
  - The block then enters state DROPi: si_rd = si_vld, beats are discarded without forwarding, and it returns to IDLE after the discarded eop beat.
- When not defined: no beat counter, no DROP states, and MAX_LEN is ignored.

Test Plan:
- Port 0 only, 4-beat packet (sop on 0x11, eop on 0x44), out_rdy=1 → dout 0x11..0x44 on 4 consecutive cycles starting 1 cycle after the first s0_rd; sop on first beat, eop on last; pkt_cnt0=1.
- Both ports hold 3-beat packets continuously, out_rdy=1 → packets alternate 0,1,0,1; no interleaving; one idle cycle between packets; after 4 packets pkt_cnt0=pkt_cnt1=2.
- Port 1 mid-packet, out_rdy toggles 1,0,0,1 → s1_rd follows out_rdy; dout_vld pattern 1,0,0 is delayed one cycle from the out_rdy pattern; no beat lost or duplicated.
- Port 0 presents a non-sop beat in IDLE → s0_rd=1 for one cycle, err pulses once, dout_vld stays 0, pkt_cnt0 unchanged.
- rst asserted for 1 cycle on beat 2 of a 5-beat packet → all outputs 0 next cycle; state IDLE; the next sop from either port is granted normally.
- PKT_LEN_CHK_EN, MAX_LEN=4, 6-beat packet on port 0 → 4 beats forwarded, the 4th with dout_eop=1; err pulses; beats 5-6 discarded; pkt_cnt0=1; next packet forwarded normally.

Source files
------------

// File: rtl/pkt_rr_arb2.sv
// pkt_rr_arb2: two-input, packet-granular round-robin arbiter.
// Merges two show-ahead packet FIFO read ports ({sop, eop, data}) onto one
// registered downstream stream. A granted packet keeps the grant until its
// eop beat is transferred, so packets never interleave.
// Optional build macro PKT_LEN_CHK_EN: truncates packets longer than MAX_LEN
// beats (forced eop + err) and drains the remainder in a DROP state.
module pkt_rr_arb2 #(
   parameter int DATA_W  = 8,
   parameter int MAX_LEN = 256,
   parameter int CNT_W   = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] s0_dat,
   input  logic              s0_vld,
   input  logic              s0_sop,
   input  logic              s0_eop,
   output logic              s0_rd,
   input  logic [DATA_W-1:0] s1_dat,
   input  logic              s1_vld,
   input  logic              s1_sop,
   input  logic              s1_eop,
   output logic              s1_rd,
   output logic [DATA_W-1:0] dout,
   output logic              dout_vld,
   output logic              dout_sop,
   output logic              dout_eop,
   input  logic              out_rdy,
   output logic              err,
   output logic [CNT_W-1:0]  pkt_cnt0,
   output logic [CNT_W-1:0]  pkt_cnt1
);

`ifdef PKT_LEN_CHK_EN
   typedef enum logic [2:0] {IDLE, GNT0, GNT1, DROP0, DROP1} state_t;
   localparam int LEN_W = $clog2(MAX_LEN + 1);
   logic [LEN_W-1:0] len_q, len_d;
`else
   typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;
   // MAX_LEN only matters when the length check is built in.
   logic unused_max_len;
   assign unused_max_len = (MAX_LEN > 0);
`endif

   state_t state_q, state_d;
   logic   ptr_q, ptr_d;      // 1: port 1 has priority on a tie
   logic   gap_q, gap_d;      // forces the idle cycle after a packet ends

   logic              req0, req1, stray0, stray1;
   logic              gsel, port_sel;
   logic              b_vld, b_sop, b_eop;
   logic [DATA_W-1:0] b_dat;
   logic              rd0_c, rd1_c;
   logic              fwd, fwd_sop, fwd_eop, err_c;

   logic [DATA_W-1:0] dout_q;
   logic              dout_vld_q, dout_sop_q, dout_eop_q, err_q;
   logic [CNT_W-1:0]  cnt0_q, cnt1_q;

   assign req0   = s0_vld & s0_sop;
   assign req1   = s1_vld & s1_sop;
   assign stray0 = s0_vld & ~s0_sop;
   assign stray1 = s1_vld & ~s1_sop;
   // On a tie the pointer decides; otherwise the lone requester wins.
   assign gsel   = (req0 & req1) ? ptr_q : req1;

   // Select which port's head beat the datapath looks at this cycle.
   always_comb begin
      port_sel = gsel;
      case (state_q)
         GNT0:    port_sel = 1'b0;
         GNT1:    port_sel = 1'b1;
`ifdef PKT_LEN_CHK_EN
         DROP0:   port_sel = 1'b0;
         DROP1:   port_sel = 1'b1;
`endif
         default: port_sel = gsel;
      endcase
   end

   assign b_vld = port_sel ? s1_vld : s0_vld;
   assign b_sop = port_sel ? s1_sop : s0_sop;
   assign b_eop = port_sel ? s1_eop : s0_eop;
   assign b_dat = port_sel ? s1_dat : s0_dat;

   // Next-state, read requests and forward decision.
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      gap_d   = 1'b0;
      rd0_c   = 1'b0;
      rd1_c   = 1'b0;
      fwd     = 1'b0;
      fwd_sop = 1'b0;
      fwd_eop = 1'b0;
      err_c   = 1'b0;
`ifdef PKT_LEN_CHK_EN
      len_d   = len_q;
`endif
      case (state_q)
         IDLE: begin
            if (!gap_q) begin
               // Beats without sop at a packet boundary are discarded.
               rd0_c = stray0;
               rd1_c = stray1;
               err_c = stray0 | stray1;
               if ((req0 | req1) && out_rdy) begin
                  ptr_d   = ~gsel;
                  fwd     = 1'b1;
                  fwd_sop = 1'b1;
                  fwd_eop = b_eop;
                  if (gsel) rd1_c = 1'b1;
                  else      rd0_c = 1'b1;
                  if (b_eop) gap_d = 1'b1;
`ifdef PKT_LEN_CHK_EN
                  else if (MAX_LEN == 1) begin
                     fwd_eop = 1'b1;
                     err_c   = 1'b1;
                     state_d = gsel ? DROP1 : DROP0;
                  end else begin
                     len_d   = LEN_W'(1);
                     state_d = gsel ? GNT1 : GNT0;
                  end
`else
                  else state_d = gsel ? GNT1 : GNT0;
`endif
               end
            end
         end
         GNT0, GNT1: begin
            if (b_vld && out_rdy) begin
               if (port_sel) rd1_c = 1'b1;
               else          rd0_c = 1'b1;
               fwd     = 1'b1;
               fwd_eop = b_eop;
               // A sop inside a packet is passed on as a plain data beat.
               if (b_sop) err_c = 1'b1;
               if (b_eop) begin
                  state_d = IDLE;
                  gap_d   = 1'b1;
               end
`ifdef PKT_LEN_CHK_EN
               else if (len_q == LEN_W'(MAX_LEN - 1)) begin
                  fwd_eop = 1'b1;
                  err_c   = 1'b1;
                  state_d = port_sel ? DROP1 : DROP0;
               end else begin
                  len_d = len_q + LEN_W'(1);
               end
`endif
            end
         end
`ifdef PKT_LEN_CHK_EN
         DROP0, DROP1: begin
            // Drain the rest of a truncated packet without forwarding.
            if (b_vld) begin
               if (port_sel) rd1_c = 1'b1;
               else          rd0_c = 1'b1;
               if (b_eop) begin
                  state_d = IDLE;
                  gap_d   = 1'b1;
               end
            end
         end
`endif
         default: state_d = IDLE;
      endcase
   end

   // Nothing is consumed from the FIFOs while reset is held.
   assign s0_rd = rd0_c & ~rst;
   assign s1_rd = rd1_c & ~rst;

   // Control state: FSM, round-robin pointer, inter-packet gap.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         ptr_q   <= 1'b0;
         gap_q   <= 1'b0;
`ifdef PKT_LEN_CHK_EN
         len_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         gap_q   <= gap_d;
`ifdef PKT_LEN_CHK_EN
         len_q   <= len_d;
`endif
      end
   end

   // Output beat register, one cycle after the FIFO read.
   always_ff @(posedge clk) begin
      if (rst) begin
         dout_q     <= '0;
         dout_vld_q <= 1'b0;
         dout_sop_q <= 1'b0;
         dout_eop_q <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         dout_vld_q <= fwd;
         if (fwd) dout_q <= b_dat;
         dout_sop_q <= fwd & fwd_sop;
         dout_eop_q <= fwd & fwd_eop;
         err_q      <= err_c;
      end
   end

   // Per-port packet counters, bumped on every forwarded eop.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt0_q <= '0;
         cnt1_q <= '0;
      end else if (fwd && fwd_eop) begin
         if (port_sel) cnt1_q <= cnt1_q + CNT_W'(1);
         else          cnt0_q <= cnt0_q + CNT_W'(1);
      end
   end

   assign dout     = dout_q;
   assign dout_vld = dout_vld_q;
   assign dout_sop = dout_sop_q;
   assign dout_eop = dout_eop_q;
   assign err      = err_q;
   assign pkt_cnt0 = cnt0_q;
   assign pkt_cnt1 = cnt1_q;

endmodule

// File: tb/tb_pkt_rr_arb2.sv
// Scoreboard bench for pkt_rr_arb2: bench-side FIFO models feed the ports,
// expected beats are queued at stimulus time and a monitor checks dout.
module tb_pkt_rr_arb2;
   localparam int DW = 8;
   localparam int CW = 16;
`ifdef PKT_LEN_CHK_EN
   localparam int ML = 4;
`else
   localparam int ML = 256;
`endif

   typedef struct packed {
      logic [7:0] d;
      logic       s;
      logic       e;
   } beat_t;

   logic          clk = 1'b0;
   logic          rst;
   logic [DW-1:0] s0_dat, s1_dat, dout;
   logic          s0_vld, s0_sop, s0_eop, s0_rd;
   logic          s1_vld, s1_sop, s1_eop, s1_rd;
   logic          dout_vld, dout_sop, dout_eop, out_rdy, err;
   logic [CW-1:0] pkt_cnt0, pkt_cnt1;

   beat_t q0[$], q1[$], exp_q[$];
   int    out_cyc[$], rd0_cyc[$], rd1_cyc[$];
   int    cyc = 0;
   int    tot = 0;
   int    bad = 0;
   int    err_cnt = 0;
   logic  tk0 = 1'b0;
   logic  tk1 = 1'b0;

   pkt_rr_arb2 #(.DATA_W(DW), .MAX_LEN(ML), .CNT_W(CW)) dut (
      .clk(clk), .rst(rst),
      .s0_dat(s0_dat), .s0_vld(s0_vld), .s0_sop(s0_sop), .s0_eop(s0_eop), .s0_rd(s0_rd),
      .s1_dat(s1_dat), .s1_vld(s1_vld), .s1_sop(s1_sop), .s1_eop(s1_eop), .s1_rd(s1_rd),
      .dout(dout), .dout_vld(dout_vld), .dout_sop(dout_sop), .dout_eop(dout_eop),
      .out_rdy(out_rdy), .err(err), .pkt_cnt0(pkt_cnt0), .pkt_cnt1(pkt_cnt1)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tot++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic drive();
      if (q0.size() > 0) begin
         s0_vld = 1'b1; s0_dat = q0[0].d; s0_sop = q0[0].s; s0_eop = q0[0].e;
      end else begin
         s0_vld = 1'b0; s0_dat = '0; s0_sop = 1'b0; s0_eop = 1'b0;
      end
      if (q1.size() > 0) begin
         s1_vld = 1'b1; s1_dat = q1[0].d; s1_sop = q1[0].s; s1_eop = q1[0].e;
      end else begin
         s1_vld = 1'b0; s1_dat = '0; s1_sop = 1'b0; s1_eop = 1'b0;
      end
   endtask

   task automatic src(input int port, input logic [7:0] d, input logic s, input logic e);
      beat_t b;
      b.d = d; b.s = s; b.e = e;
      if (port == 0) q0.push_back(b);
      else           q1.push_back(b);
   endtask

   task automatic expb(input logic [7:0] d, input logic s, input logic e);
      beat_t b;
      b.d = d; b.s = s; b.e = e;
      exp_q.push_back(b);
   endtask

   task automatic clr_logs();
      out_cyc.delete();
      rd0_cyc.delete();
      rd1_cyc.delete();
   endtask

   task automatic wait_done(input string name);
      int n;
      n = 0;
      while ((q0.size() > 0 || q1.size() > 0 || exp_q.size() > 0) && n < 200) begin
         @(posedge clk);
         n++;
      end
      chk({name, "_done"}, 32'(n < 200), 32'd1);
      repeat (3) @(posedge clk);
      #1;
   endtask

   // Record FIFO reads at the active edge.
   always @(posedge clk) begin
      tk0 <= s0_vld & s0_rd;
      tk1 <= s1_vld & s1_rd;
      if (s0_vld && s0_rd) rd0_cyc.push_back(cyc);
      if (s1_vld && s1_rd) rd1_cyc.push_back(cyc);
      cyc <= cyc + 1;
   end

   // FIFO models pop consumed beats and present the next head.
   always @(negedge clk) begin
      if (tk0 && q0.size() > 0) void'(q0.pop_front());
      if (tk1 && q1.size() > 0) void'(q1.pop_front());
      drive();
   end

   // Monitor: compare every output beat against the scoreboard.
   always @(negedge clk) begin
      beat_t e;
      if (err === 1'b1) err_cnt++;
      if (dout_vld === 1'b1) begin
         out_cyc.push_back(cyc);
         if (exp_q.size() == 0) begin
            tot++;
            bad++;
            $display("FAIL extra_beat: got %0h want none", {dout, dout_sop, dout_eop});
         end else begin
            e = exp_q.pop_front();
            chk("beat", 32'({dout, dout_sop, dout_eop}), 32'({e.d, e.s, e.e}));
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int    n;
      int    e0;
      logic  pat[4];
      pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
      rst = 1'b1;
      out_rdy = 1'b1;
      drive();
      repeat (2) @(posedge clk);
      #1;
      chk("rst_vld", 32'(dout_vld), 32'd0);
      chk("rst_dout", 32'(dout), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      chk("rst_cnt0", 32'(pkt_cnt0), 32'd0);
      chk("rst_cnt1", 32'(pkt_cnt1), 32'd0);
      chk("rst_rd0", 32'(s0_rd), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;

      // Both ports hold two 3-beat packets: order 0,1,0,1 with gaps.
      clr_logs();
      for (int p = 0; p < 2; p++) begin
         src(0, 8'hA0 + 8'(3*p), 1'b1, 1'b0);
         src(0, 8'hA1 + 8'(3*p), 1'b0, 1'b0);
         src(0, 8'hA2 + 8'(3*p), 1'b0, 1'b1);
         src(1, 8'hB0 + 8'(3*p), 1'b1, 1'b0);
         src(1, 8'hB1 + 8'(3*p), 1'b0, 1'b0);
         src(1, 8'hB2 + 8'(3*p), 1'b0, 1'b1);
      end
      for (int p = 0; p < 2; p++) begin
         expb(8'hA0 + 8'(3*p), 1'b1, 1'b0);
         expb(8'hA1 + 8'(3*p), 1'b0, 1'b0);
         expb(8'hA2 + 8'(3*p), 1'b0, 1'b1);
         expb(8'hB0 + 8'(3*p), 1'b1, 1'b0);
         expb(8'hB1 + 8'(3*p), 1'b0, 1'b0);
         expb(8'hB2 + 8'(3*p), 1'b0, 1'b1);
      end
      wait_done("t2");
      chk("t2_nbeats", 32'(out_cyc.size()), 32'd12);
      for (int i = 1; i < out_cyc.size() && i < 12; i++)
         chk("t2_spacing", 32'(out_cyc[i] - out_cyc[i-1]), (i % 3 == 0) ? 32'd2 : 32'd1);
      chk("t2_cnt0", 32'(pkt_cnt0), 32'd2);
      chk("t2_cnt1", 32'(pkt_cnt1), 32'd2);
      chk("t2_err", 32'(err_cnt), 32'd0);

      // Port 0 alone, 4-beat packet 0x11..0x44.
      clr_logs();
      src(0, 8'h11, 1'b1, 1'b0); src(0, 8'h22, 1'b0, 1'b0);
      src(0, 8'h33, 1'b0, 1'b0); src(0, 8'h44, 1'b0, 1'b1);
      expb(8'h11, 1'b1, 1'b0); expb(8'h22, 1'b0, 1'b0);
      expb(8'h33, 1'b0, 1'b0); expb(8'h44, 1'b0, 1'b1);
      wait_done("t1");
      chk("t1_nbeats", 32'(out_cyc.size()), 32'd4);
      chk("t1_latency", (out_cyc.size() > 0 && rd0_cyc.size() > 0) ?
          32'(out_cyc[0] - rd0_cyc[0]) : 32'hFFFF, 32'd1);
      chk("t1_burst", (out_cyc.size() == 4) ? 32'(out_cyc[3] - out_cyc[0]) : 32'hFFFF, 32'd3);
      chk("t1_cnt0", 32'(pkt_cnt0), 32'd3);

      // Port 1 mid-packet with out_rdy pattern 1,0,0,1.
      clr_logs();
      src(1, 8'hC0, 1'b1, 1'b0); src(1, 8'hC1, 1'b0, 1'b0);
      src(1, 8'hC2, 1'b0, 1'b0); src(1, 8'hC3, 1'b0, 1'b1);
      expb(8'hC0, 1'b1, 1'b0); expb(8'hC1, 1'b0, 1'b0);
      expb(8'hC2, 1'b0, 1'b0); expb(8'hC3, 1'b0, 1'b1);
      n = 0;
      while (rd1_cyc.size() < 2 && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("t3_start", 32'(n < 50), 32'd1);
      for (int i = 0; i < 4; i++) begin
         out_rdy = pat[i];
         #1;
         chk("t3_rd1", 32'(s1_rd), 32'(pat[i]));
         @(posedge clk);
         #1;
         chk("t3_vld", 32'(dout_vld), 32'(pat[i]));
         @(negedge clk);
      end
      out_rdy = 1'b1;
      wait_done("t3");
      chk("t3_nbeats", 32'(out_cyc.size()), 32'd4);
      chk("t3_cnt1", 32'(pkt_cnt1), 32'd3);

      // Stray non-sop beat on port 0 while idle.
      clr_logs();
      e0 = err_cnt;
      src(0, 8'h55, 1'b0, 1'b0);
      wait_done("t4");
      chk("t4_rd0", 32'(rd0_cyc.size()), 32'd1);
      chk("t4_err", 32'(err_cnt - e0), 32'd1);
      chk("t4_nout", 32'(out_cyc.size()), 32'd0);
      chk("t4_cnt0", 32'(pkt_cnt0), 32'd3);

      // Reset during beat 2 of a 5-beat packet.
      clr_logs();
      src(0, 8'hD0, 1'b1, 1'b0); src(0, 8'hD1, 1'b0, 1'b0);
      src(0, 8'hD2, 1'b0, 1'b0); src(0, 8'hD3, 1'b0, 1'b0);
      src(0, 8'hD4, 1'b0, 1'b1);
      expb(8'hD0, 1'b1, 1'b0);
      n = 0;
      while (rd0_cyc.size() < 1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("t5_start", 32'(n < 50), 32'd1);
      rst = 1'b1;
      q0.delete();
      drive();
      @(posedge clk);
      #1;
      chk("t5_vld", 32'(dout_vld), 32'd0);
      chk("t5_dout", 32'(dout), 32'd0);
      chk("t5_flags", 32'({dout_sop, dout_eop, err}), 32'd0);
      chk("t5_rd", 32'({s0_rd, s1_rd}), 32'd0);
      chk("t5_cnt", 32'({pkt_cnt0, pkt_cnt1}), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      src(1, 8'hE0, 1'b1, 1'b0); src(1, 8'hE1, 1'b0, 1'b1);
      expb(8'hE0, 1'b1, 1'b0); expb(8'hE1, 1'b0, 1'b1);
      wait_done("t5");
      chk("t5_cnt1", 32'(pkt_cnt1), 32'd1);
      chk("t5_cnt0", 32'(pkt_cnt0), 32'd0);

`ifdef PKT_LEN_CHK_EN
      // Over-length packet: truncated at MAX_LEN, remainder dropped.
      clr_logs();
      e0 = err_cnt;
      src(0, 8'hF0, 1'b1, 1'b0);
      for (int i = 1; i < 5; i++) src(0, 8'hF0 + 8'(i), 1'b0, 1'b0);
      src(0, 8'hF5, 1'b0, 1'b1);
      src(0, 8'h60, 1'b1, 1'b0); src(0, 8'h61, 1'b0, 1'b1);
      expb(8'hF0, 1'b1, 1'b0); expb(8'hF1, 1'b0, 1'b0);
      expb(8'hF2, 1'b0, 1'b0); expb(8'hF3, 1'b0, 1'b1);
      expb(8'h60, 1'b1, 1'b0); expb(8'h61, 1'b0, 1'b1);
      wait_done("t6");
      chk("t6_rd0", 32'(rd0_cyc.size()), 32'd8);
      chk("t6_nout", 32'(out_cyc.size()), 32'd6);
      chk("t6_err", 32'(err_cnt - e0), 32'd1);
      chk("t6_cnt0", 32'(pkt_cnt0), 32'd2);
`endif

      $display("test done: total=%0d bad=%0d", tot, bad);
      $finish;
   end
endmodule
